// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types for Wishbone arbiters: grant state encoding, the request bundle a
// master presents, and the round-robin pick used when the bus is idle.
package wb_arbiter_2m_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [19:1]       adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic              stb;
    logic              cyc;
  } wb_req_t;

  // On a tie the master that did not own the bus most recently wins.
  function automatic arb_state_t rr_pick(input logic req0, input logic req1,
                                         input logic last);
    arb_state_t pick;
    case ({req1, req0})
      2'b01:   pick = GNT0;
      2'b10:   pick = GNT1;
      2'b11:   pick = last ? GNT0 : GNT1;
      default: pick = IDLE;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter in front of one 16-bit slave port. The grant is
// registered and held for the owner's whole cyc; simultaneous requests alternate.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [19:1] m0_adr_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,

  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [19:1] m1_adr_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,

  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic [19:1] s_adr_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       last_nxt;
  wb_req_t    m0_req;
  wb_req_t    m1_req;
  wb_req_t    owner_req;
  logic       gnt0;
  logic       gnt1;

  // last starts at 1 so that m0 wins the very first tie.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: state_nxt = rr_pick(m0_cyc_i, m1_cyc_i, last);
      GNT0: if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GNT0 && state != GNT0) last_nxt = 1'b0;
    if (state_nxt == GNT1 && state != GNT1) last_nxt = 1'b1;
  end

  assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i,
                    we: m0_we_i, stb: m0_stb_i, cyc: m0_cyc_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i,
                    we: m1_we_i, stb: m1_stb_i, cyc: m1_cyc_i};

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  // Idle drives an all-zero request so nothing leaks onto the slave port.
  always_comb begin
    owner_req = '0;
    case (state)
      GNT0:    owner_req = m0_req;
      GNT1:    owner_req = m1_req;
      default: owner_req = '0;
    endcase
  end

  // Gating with the owner's live cyc ends the slave cycle before the grant moves.
  assign s_cyc_o = owner_req.cyc;
  assign s_stb_o = owner_req.stb & owner_req.cyc;
  assign s_we_o  = owner_req.we;
  assign s_adr_o = owner_req.adr;
  assign s_sel_o = owner_req.sel;
  assign s_dat_o = owner_req.dat;

  assign m0_ack_o = s_ack_i & gnt0;
  assign m1_ack_o = s_ack_i & gnt1;
  assign m0_dat_o = gnt0 ? s_dat_i : 16'h0000;
  assign m1_dat_o = gnt1 ? s_dat_i : 16'h0000;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m in front of a zero-delay 16-bit memory.
// Stimulus pushes expected grant order and read data; a monitor checks every ack.
module tb_wb_arbiter_2m;

  typedef struct {
    logic        isRead;
    logic [15:0] data;
  } exp_t;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [15:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o;
  logic [19:1] m0_adr_i, m1_adr_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o;
  logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o;
  logic [1:0]  m0_sel_i, m1_sel_i;
  logic [15:0] s_dat_o, s_dat_i;
  logic [19:1] s_adr_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]  s_sel_o;

  logic [15:0] mem [0:255];

  int   checks   = 0;
  int   failures = 0;
  int   expGnt[$];
  exp_t expQ0[$];
  exp_t expQ1[$];

  wb_arbiter_2m dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_adr_i(m0_adr_i),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
    .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_adr_i(m1_adr_i),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_adr_o(s_adr_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Zero-delay memory: combinational ack and read data, byte-selected write at the edge.
  assign s_ack_i = s_cyc_o & s_stb_o;
  assign s_dat_i = mem[s_adr_o[8:1]];

  always @(posedge wb_clk_i) begin
    if (s_cyc_o && s_stb_o && s_we_o) begin
      if (s_sel_o[0]) mem[s_adr_o[8:1]][7:0]  <= s_dat_o[7:0];
      if (s_sel_o[1]) mem[s_adr_o[8:1]][15:8] <= s_dat_o[15:8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [19:1] adr,
                               input logic [15:0] dat, input logic [1:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Counts the negedges that pass without an ack to master m.
  task automatic waitAck(input int m, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wb_clk_i);
      if ((m == 0) ? m0_ack_o : m1_ack_o) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout master=%0d actual=no_ack expected=ack", m);
    end
  endtask

  task automatic doXfer(input int m, input logic we, input logic [19:1] adr,
                        input logic [15:0] dat, input logic [1:0] sel,
                        input logic [15:0] expRd, input logic keepCyc,
                        output int lat);
    exp_t e;
    e.isRead = !we;
    e.data   = expRd;
    if (m == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
    applyStimulus(m, 1'b1, 1'b1, we, adr, dat, sel);
    waitAck(m, lat);
    @(posedge wb_clk_i);
    #1;
    applyStimulus(m, keepCyc, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic handleAck(input int m);
    exp_t e;
    int   g;
    if (expGnt.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_ack actual=master%0d expected=none", m);
    end else begin
      g = expGnt.pop_front();
      checkOutput("grant_order", m, g);
    end
    if (m == 0) begin
      if (expQ0.size() != 0) begin
        e = expQ0.pop_front();
        if (e.isRead) checkOutput("m0_rdata", m0_dat_o, e.data);
      end
      checkOutput("m1_dat_zero", m1_dat_o, 0);
    end else begin
      if (expQ1.size() != 0) begin
        e = expQ1.pop_front();
        if (e.isRead) checkOutput("m1_rdata", m1_dat_o, e.data);
      end
      checkOutput("m0_dat_zero", m0_dat_o, 0);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (m0_ack_o && m1_ack_o)
      checkOutput("dual_ack", {m1_ack_o, m0_ack_o}, 0);
    if (m0_ack_o) handleAck(0);
    if (m1_ack_o) handleAck(1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat0, lat1;

    // Reset with m0 driving a live request: everything must stay at zero.
    wb_rst_i = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 19'h00077, 16'hFFFF, 2'b11);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(2);
    checkOutput("rst_s_cyc", s_cyc_o, 0);
    checkOutput("rst_s_stb", s_stb_o, 0);
    checkOutput("rst_s_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, 0);
    checkOutput("rst_acks", {m1_ack_o, m0_ack_o}, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    wb_rst_i = 1'b0;
    idle(1);

    // Simultaneous first request: m0 first, m1 straight after with no idle cycle.
    expGnt.push_back(0);
    expGnt.push_back(1);
    fork
      doXfer(0, 1'b1, 19'h00001, 16'h0A0A, 2'b11, 16'h0, 1'b0, lat0);
      begin
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 19'h00002, 16'h0B0B, 2'b11);
        #1;
        checkOutput("idle_s_stb", s_stb_o, 0);
        checkOutput("idle_s_adr", s_adr_o, 0);
        doXfer(1, 1'b1, 19'h00002, 16'h0B0B, 2'b11, 16'h0, 1'b0, lat1);
      end
    join
    checkOutput("sim_m0_latency", lat0, 1);
    checkOutput("sim_m1_handover", lat1, 3);
    idle(2);

    // Round-robin with single-transfer cycles from both masters.
    for (int i = 0; i < 4; i++) begin
      expGnt.push_back(0);
      expGnt.push_back(1);
    end
    fork
      for (int i = 0; i < 4; i++) begin
        doXfer(0, 1'b1, 19'h00060 + 19'(i), 16'h6000 + 16'(i), 2'b11, 16'h0, 1'b0, lat0);
        idle(1);
      end
      for (int j = 0; j < 4; j++) begin
        doXfer(1, 1'b1, 19'h00070 + 19'(j), 16'h7000 + 16'(j), 2'b11, 16'h0, 1'b0, lat1);
        idle(1);
      end
    join
    idle(2);

    // Single master write then read.
    expGnt.push_back(0);
    doXfer(0, 1'b1, 19'h00010, 16'hBEEF, 2'b11, 16'h0, 1'b0, lat0);
    checkOutput("m0_wr_latency", lat0, 1);
    idle(1);
    expGnt.push_back(0);
    doXfer(0, 1'b0, 19'h00010, 16'h0, 2'b11, 16'hBEEF, 1'b0, lat0);
    checkOutput("m0_rd_latency", lat0, 1);
    idle(2);

    // Lock: m1 holds cyc across read, 3 idle-stb cycles and write while m0 waits.
    expGnt.push_back(1);
    doXfer(1, 1'b1, 19'h00020, 16'h5A5A, 2'b11, 16'h0, 1'b0, lat1);
    idle(1);
    expGnt.push_back(1);
    expGnt.push_back(1);
    expGnt.push_back(0);
    doXfer(1, 1'b0, 19'h00020, 16'h0, 2'b11, 16'h5A5A, 1'b1, lat1);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 19'h00030, 16'h7777, 2'b11);
    expQ0.push_back('{1'b0, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      checkOutput("lock_m0_ack", m0_ack_o, 0);
      checkOutput("lock_s_cyc", s_cyc_o, 1);
      checkOutput("lock_s_stb", s_stb_o, 0);
      @(posedge wb_clk_i);
      #1;
    end
    doXfer(1, 1'b1, 19'h00020, 16'h1234, 2'b11, 16'h0, 1'b0, lat1);
    checkOutput("lock_wr_latency", lat1, 0);
    waitAck(0, lat0);
    checkOutput("lock_m0_wait", lat0, 1);
    @(posedge wb_clk_i);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(1);
    expGnt.push_back(1);
    doXfer(1, 1'b0, 19'h00020, 16'h0, 2'b11, 16'h1234, 1'b0, lat1);
    idle(2);

    // Byte select: only the low byte is replaced.
    expGnt.push_back(1);
    doXfer(1, 1'b1, 19'h00040, 16'h1111, 2'b11, 16'h0, 1'b0, lat1);
    idle(1);
    expGnt.push_back(1);
    doXfer(1, 1'b1, 19'h00040, 16'hAA55, 2'b01, 16'h0, 1'b0, lat1);
    idle(1);
    expGnt.push_back(1);
    doXfer(1, 1'b0, 19'h00040, 16'h0, 2'b11, 16'h1155, 1'b0, lat1);
    idle(2);

    // Reset in the middle of an un-acked m0 write.
    expGnt.push_back(0);
    doXfer(0, 1'b1, 19'h00050, 16'h4321, 2'b11, 16'h0, 1'b0, lat0);
    idle(1);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 19'h00050, 16'hDEAD, 2'b11);
    @(posedge wb_clk_i);
    #2;
    checkOutput("pre_rst_s_stb", s_stb_o, 1);
    wb_rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_s_stb", s_stb_o, 0);
    checkOutput("mid_rst_s_cyc", s_cyc_o, 0);
    checkOutput("mid_rst_acks", {m1_ack_o, m0_ack_o}, 0);
    @(posedge wb_clk_i);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    wb_rst_i = 1'b0;
    checkOutput("rst_mem_unchanged", mem[8'h50], 16'h4321);
    idle(1);

    // After reset the tie goes to m0 again.
    expGnt.push_back(0);
    expGnt.push_back(1);
    fork
      doXfer(0, 1'b0, 19'h00050, 16'h0, 2'b11, 16'h4321, 1'b0, lat0);
      doXfer(1, 1'b0, 19'h00040, 16'h0, 2'b11, 16'h1155, 1'b0, lat1);
    join
    checkOutput("post_rst_m0_latency", lat0, 1);
    checkOutput("post_rst_m1_handover", lat1, 3);
    idle(2);

    checkOutput("scoreboard_drained", expGnt.size() + expQ0.size() + expQ1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
